// File: rtl/exe_lat_pipe_if.sv
// rtl/exe_lat_pipe_if.sv - issue, hazard-check and retire signals of the execute latency pipe
interface exe_lat_pipe_if #(
    parameter int DEPTH      = 4,
    parameter int PAYLOAD_W  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = $clog2(DEPTH + 1)
);
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [LAT_W-1:0]      issue_lat_i;
    logic [REG_ADDR_W-1:0] issue_rd_i;
    logic                  issue_we_i;
    logic [PAYLOAD_W-1:0]  issue_payload_i;
    logic                  illegal_lat_o;
    logic [REG_ADDR_W-1:0] chk_rs1_i;
    logic [REG_ADDR_W-1:0] chk_rs2_i;
    logic                  hazard_rs1_o;
    logic                  hazard_rs2_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [REG_ADDR_W-1:0] out_rd_o;
    logic                  out_we_o;
    logic [PAYLOAD_W-1:0]  out_payload_o;
    logic [LAT_W-1:0]      occupancy_o;

    modport slave (
        input  issue_valid_i, issue_lat_i, issue_rd_i, issue_we_i, issue_payload_i,
        input  chk_rs1_i, chk_rs2_i, out_ready_i,
        output issue_ready_o, illegal_lat_o, hazard_rs1_o, hazard_rs2_o,
        output out_valid_o, out_rd_o, out_we_o, out_payload_o, occupancy_o
    );

    modport master (
        output issue_valid_i, issue_lat_i, issue_rd_i, issue_we_i, issue_payload_i,
        output chk_rs1_i, chk_rs2_i, out_ready_i,
        input  issue_ready_o, illegal_lat_o, hazard_rs1_o, hazard_rs2_o,
        input  out_valid_o, out_rd_o, out_we_o, out_payload_o, occupancy_o
    );
endinterface

// File: rtl/exe_lat_pipe.sv
// rtl/exe_lat_pipe.sv - fixed-slot retire pipe placing each op so it retires LAT cycles after issue
module exe_lat_pipe #(
    parameter int DEPTH      = 4,
    parameter int PAYLOAD_W  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    exe_lat_pipe_if.slave bus
);
    localparam int LAT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      slot_valid;
    logic [REG_ADDR_W-1:0] slot_rd      [DEPTH];
    logic                  slot_we      [DEPTH];
    logic [PAYLOAD_W-1:0]  slot_payload [DEPTH];
    logic [LAT_W-1:0]      occ;

    logic lat_ok;
    logic coll;
    logic adv;
    logic fire;
    logic out_valid;
    logic retire;
    logic haz1;
    logic haz2;

    // Slot i holds an op that still needs DEPTH-1-i shifts; a target slot collides
    // when the op one slot upstream is about to shift into it.
    always_comb begin
        lat_ok = (bus.issue_lat_i != '0) && (bus.issue_lat_i <= LAT_W'(DEPTH));
        coll   = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (slot_valid[i] && (bus.issue_lat_i == LAT_W'(DEPTH - 1 - i))) begin
                coll = 1'b1;
            end
        end
        coll = coll & lat_ok;
    end

    assign adv       = ~slot_valid[DEPTH-1] | bus.out_ready_i;
    assign fire      = bus.issue_valid_i & lat_ok & adv & ~coll & ~flush_i & ~rst_i;
    assign out_valid = slot_valid[DEPTH-1] & ~flush_i;
    assign retire    = out_valid & bus.out_ready_i;

    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && slot_we[i] && (slot_rd[i] == bus.chk_rs1_i)) haz1 = 1'b1;
            if (slot_valid[i] && slot_we[i] && (slot_rd[i] == bus.chk_rs2_i)) haz2 = 1'b1;
        end
        haz1 = haz1 & (bus.chk_rs1_i != '0);
        haz2 = haz2 & (bus.chk_rs2_i != '0);
    end

    assign bus.issue_ready_o = fire;
    assign bus.illegal_lat_o = bus.issue_valid_i & ~lat_ok;
    assign bus.hazard_rs1_o  = haz1;
    assign bus.hazard_rs2_o  = haz2;
    assign bus.out_valid_o   = out_valid;
    assign bus.out_rd_o      = slot_rd[DEPTH-1];
    assign bus.out_we_o      = slot_we[DEPTH-1];
    assign bus.out_payload_o = slot_payload[DEPTH-1];
    assign bus.occupancy_o   = occ;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            slot_valid <= '0;
            occ        <= '0;
        end else if (adv) begin
            for (int i = 1; i < DEPTH; i++) begin
                slot_valid[i]   <= slot_valid[i-1];
                slot_rd[i]      <= slot_rd[i-1];
                slot_we[i]      <= slot_we[i-1];
                slot_payload[i] <= slot_payload[i-1];
            end
            slot_valid[0] <= 1'b0;
            // The issued op lands after the shift, overriding whatever moved in.
            for (int i = 0; i < DEPTH; i++) begin
                if (fire && (bus.issue_lat_i == LAT_W'(DEPTH - i))) begin
                    slot_valid[i]   <= 1'b1;
                    slot_rd[i]      <= bus.issue_rd_i;
                    slot_we[i]      <= bus.issue_we_i;
                    slot_payload[i] <= bus.issue_payload_i;
                end
            end
            occ <= occ + LAT_W'(fire) - LAT_W'(retire);
        end
    end
endmodule

// File: tb/tb_exe_lat_pipe.sv
// tb/tb_exe_lat_pipe.sv - randomized scoreboard bench for exe_lat_pipe
module tb_exe_lat_pipe;
    localparam int DEPTH = 4;
    localparam int PW    = 32;
    localparam int RW    = 5;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int NCYC  = 4000;

    typedef struct {
        logic [RW-1:0] rd;
        logic          we;
        logic [PW-1:0] payload;
        int            due;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   adv_cnt  = 0;
    op_t  model[$];
    op_t  sb[$];

    exe_lat_pipe_if #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .REG_ADDR_W(RW)) bus ();

    exe_lat_pipe #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .REG_ADDR_W(RW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (adv %0d)", name, act, exp, adv_cnt);
        end
    endtask

    // Monitor: each accepted retirement must match the in-flight op due at this advance count.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
                int idx;
                idx = -1;
                foreach (sb[k]) if (sb[k].due == adv_cnt) idx = k;
                n_checks++;
                if (idx < 0) begin
                    n_fail++;
                    $display("FAIL retire_unexpected: got rd %0h expected no retirement", bus.out_rd_o);
                end else begin
                    chk("out_rd", PW'(bus.out_rd_o), PW'(sb[idx].rd));
                    chk("out_we", PW'(bus.out_we_o), PW'(sb[idx].we));
                    chk("out_payload", bus.out_payload_o, sb[idx].payload);
                    sb.delete(idx);
                end
            end
        end
    end

    initial begin
        int lat;
        int pidx;
        bit present, e_adv, lat_ok, e_coll, e_ready, h1, h2;
        op_t nop;

        rst   = 1'b1;
        flush = 1'b0;
        bus.issue_valid_i   = 1'b0;
        bus.issue_lat_i     = '0;
        bus.issue_rd_i      = '0;
        bus.issue_we_i      = 1'b0;
        bus.issue_payload_i = '0;
        bus.chk_rs1_i       = '0;
        bus.chk_rs2_i       = '0;
        bus.out_ready_i     = 1'b1;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst   = (cyc > 4) && ($urandom_range(0, 249) == 0);
            flush = (cyc > 4) && ($urandom_range(0, 49) == 0);
            bus.issue_valid_i   = ($urandom_range(0, 3) != 0);
            lat                 = $urandom_range(0, DEPTH + 1);
            bus.issue_lat_i     = LW'(lat);
            bus.issue_rd_i      = RW'($urandom_range(0, 7));
            bus.issue_we_i      = ($urandom_range(0, 3) != 0);
            bus.issue_payload_i = $urandom;
            bus.chk_rs1_i       = RW'($urandom_range(0, 7));
            bus.chk_rs2_i       = RW'($urandom_range(0, 7));
            bus.out_ready_i     = ($urandom_range(0, 3) != 0);
            #1;

            // Reference: each in-flight op is due to retire at a given advance count.
            pidx = -1;
            foreach (model[k]) if (model[k].due == adv_cnt) pidx = k;
            present = (pidx >= 0);
            e_adv   = !present || bus.out_ready_i;
            lat_ok  = (lat >= 1) && (lat <= DEPTH);
            e_coll  = 1'b0;
            h1      = 1'b0;
            h2      = 1'b0;
            foreach (model[k]) begin
                if (lat_ok && (model[k].due - adv_cnt == lat)) e_coll = 1'b1;
                if (model[k].we && model[k].rd == bus.chk_rs1_i && bus.chk_rs1_i != 0) h1 = 1'b1;
                if (model[k].we && model[k].rd == bus.chk_rs2_i && bus.chk_rs2_i != 0) h2 = 1'b1;
            end
            e_ready = bus.issue_valid_i && lat_ok && e_adv && !e_coll && !flush && !rst;

            chk("issue_ready", PW'(bus.issue_ready_o), PW'(e_ready));
            chk("illegal_lat", PW'(bus.illegal_lat_o), PW'(bus.issue_valid_i && !lat_ok));
            chk("hazard_rs1", PW'(bus.hazard_rs1_o), PW'(h1));
            chk("hazard_rs2", PW'(bus.hazard_rs2_o), PW'(h2));
            chk("out_valid", PW'(bus.out_valid_o), PW'(present && !flush));
            chk("occupancy", PW'(bus.occupancy_o), PW'(model.size()));

            nop.rd      = bus.issue_rd_i;
            nop.we      = bus.issue_we_i;
            nop.payload = bus.issue_payload_i;
            @(posedge clk);
            if (rst || flush) begin
                model.delete();
                sb.delete();
            end else if (e_adv) begin
                if (present) model.delete(pidx);
                adv_cnt++;
                if (e_ready) begin
                    nop.due = adv_cnt + lat - 1;
                    model.push_back(nop);
                    sb.push_back(nop);
                end
            end
        end

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
